// File: rtl/vram_writer.sv
// CPU-side VRAM write port: address pointer loaded by two control bytes, data bytes
// queued with an auto-incrementing pointer and committed only while the display is idle.
module vram_writer #(
    parameter int unsigned FIFO_LOG2  = 2,
    parameter int unsigned ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpuWrite,
    input  logic                  cpuMode,
    input  logic [7:0]            cpuData,
    input  logic                  displayActive,
    output logic                  busy,
    output logic                  overflow,
    output logic [FIFO_LOG2:0]    pendingCount,
    output logic                  ramChipSelect,
    output logic                  ramWriteEnabled,
    output logic [ADDR_WIDTH-1:0] ramAddress,
    output logic [7:0]            ramData
);

    localparam int unsigned DEPTH = 1 << FIFO_LOG2;
    localparam int unsigned CW    = FIFO_LOG2 + 1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [7:0]            data;
    } entry_t;

    typedef enum logic {FIRST, SECOND} toggle_t;

    toggle_t               state, state_nxt;
    logic [7:0]            low_q, low_nxt;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_nxt;

    entry_t                mem [DEPTH];
    logic [FIFO_LOG2-1:0]  wr_idx, rd_idx;
    logic [CW-1:0]         count;
    logic                  full, empty, push, pop, drop, ctrl_wr, data_wr;

    assign ctrl_wr = cpuWrite && cpuMode;
    assign data_wr = cpuWrite && !cpuMode;
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push    = data_wr && !full;
    assign drop    = data_wr && full;
    assign pop     = !displayActive && !empty;

    assign busy            = full;
    assign pendingCount    = count;
    assign ramWriteEnabled = pop;
    assign ramChipSelect   = pop;
    assign ramAddress      = mem[rd_idx].addr;
    assign ramData         = mem[rd_idx].data;

    // Address toggle and pointer registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FIRST;
            low_q <= '0;
            ptr_q <= '0;
        end else begin
            state <= state_nxt;
            low_q <= low_nxt;
            ptr_q <= ptr_nxt;
        end
    end

    // Control bytes build the pointer; any data byte re-arms the toggle to FIRST
    always_comb begin
        state_nxt = state;
        low_nxt   = low_q;
        ptr_nxt   = ptr_q;
        if (ctrl_wr) begin
            if (state == FIRST) begin
                low_nxt   = cpuData;
                state_nxt = SECOND;
            end else begin
                ptr_nxt   = ADDR_WIDTH'({cpuData, low_q});
                state_nxt = FIRST;
            end
        end else if (data_wr) begin
            state_nxt = FIRST;
            if (push) begin
                ptr_nxt = ptr_q + ADDR_WIDTH'(1);
            end
        end
    end

    // Queue storage needs no reset; occupancy is tracked separately
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_idx] <= '{addr: ptr_q, data: cpuData};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_idx   <= '0;
            rd_idx   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_idx <= wr_idx + FIFO_LOG2'(1);
            if (pop)  rd_idx <= rd_idx + FIFO_LOG2'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (drop) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vram_writer.sv
// Directed bench for vram_writer: a reference model pushes expected VRAM writes into a
// scoreboard queue, a negedge monitor pops and compares each observed write.
module tb_vram_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpuWrite;
    logic        cpuMode;
    logic [7:0]  cpuData;
    logic        displayActive;
    logic        busy;
    logic        overflow;
    logic [2:0]  pendingCount;
    logic        ramChipSelect;
    logic        ramWriteEnabled;
    logic [15:0] ramAddress;
    logic [7:0]  ramData;

    int checks = 0;
    int passed = 0;

    logic [23:0] sb[$];
    int          mcount = 0;
    logic [15:0] mptr   = '0;
    logic        mtog   = 1'b0;
    logic [7:0]  mlow   = '0;
    logic        mov    = 1'b0;
    logic        mon_en = 1'b0;

    vram_writer #(.FIFO_LOG2(2), .ADDR_WIDTH(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .cpuWrite       (cpuWrite),
        .cpuMode        (cpuMode),
        .cpuData        (cpuData),
        .displayActive  (displayActive),
        .busy           (busy),
        .overflow       (overflow),
        .pendingCount   (pendingCount),
        .ramChipSelect  (ramChipSelect),
        .ramWriteEnabled(ramWriteEnabled),
        .ramAddress     (ramAddress),
        .ramData        (ramData)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model of pointer, toggle, occupancy and sticky overflow
    always @(posedge clk) begin
        logic mpush, mpop;
        if (reset) begin
            mcount = 0;
            mptr   = '0;
            mtog   = 1'b0;
            mlow   = '0;
            mov    = 1'b0;
            sb.delete();
        end else begin
            mpop  = !displayActive && (mcount != 0);
            mpush = 1'b0;
            if (cpuWrite && cpuMode) begin
                if (!mtog) begin
                    mlow = cpuData;
                    mtog = 1'b1;
                end else begin
                    mptr = {cpuData, mlow};
                    mtog = 1'b0;
                end
            end else if (cpuWrite) begin
                mtog = 1'b0;
                if (mcount != 4) begin
                    sb.push_back({mptr, cpuData});
                    mptr  = mptr + 16'd1;
                    mpush = 1'b1;
                end else begin
                    mov = 1'b1;
                end
            end
            mcount = mcount + int'(mpush) - int'(mpop);
        end
    end

    // Monitor: every VRAM write must match the scoreboard head
    always @(negedge clk) begin
        logic [23:0] e;
        if (mon_en) begin
            chk("pending_count", int'(pendingCount), mcount);
            chk("busy", int'(busy), int'(mcount == 4));
            chk("overflow_flag", int'(overflow), int'(mov));
            chk("cs_eq_we", int'(ramChipSelect), int'(ramWriteEnabled));
            if (ramWriteEnabled === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("spurious_write", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("wr_addr", int'(ramAddress), int'(e[23:8]));
                    chk("wr_data", int'(ramData), int'(e[7:0]));
                end
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic mode, input logic [7:0] d);
        cpuWrite = 1'b1;
        cpuMode  = mode;
        cpuData  = d;
        nxt();
        cpuWrite = 1'b0;
        cpuMode  = 1'b0;
        cpuData  = '0;
    endtask

    initial begin
        reset = 1'b1; cpuWrite = 1'b0; cpuMode = 1'b0; cpuData = '0; displayActive = 1'b0;
        repeat (2) nxt();
        reset  = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        chk("rst_pending", int'(pendingCount), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_we", int'(ramWriteEnabled), 0);
        chk("rst_cs", int'(ramChipSelect), 0);

        // Address set and single write, one cycle after the strobe
        nxt();
        wr(1'b1, 8'h34); wr(1'b1, 8'h12); wr(1'b0, 8'hAB);
        @(negedge clk);
        chk("single_we", int'(ramWriteEnabled), 1);
        chk("single_addr", int'(ramAddress), 16'h1234);
        chk("single_data", int'(ramData), 8'hAB);
        nxt();
        @(negedge clk);
        chk("single_we_once", int'(ramWriteEnabled), 0);

        // Auto-increment across the 0xFFFF wrap
        nxt();
        wr(1'b1, 8'hFF); wr(1'b1, 8'hFF); wr(1'b0, 8'h01); wr(1'b0, 8'h02);
        @(negedge clk);
        chk("wrap_addr", int'(ramAddress), 16'h0000);
        chk("wrap_data", int'(ramData), 8'h02);
        repeat (2) nxt();

        // Blanking hold, fill, overflow
        displayActive = 1'b1;
        wr(1'b1, 8'h00); wr(1'b1, 8'h20);
        wr(1'b0, 8'hA0); wr(1'b0, 8'hA1); wr(1'b0, 8'hA2); wr(1'b0, 8'hA3);
        @(negedge clk);
        chk("hold_we", int'(ramWriteEnabled), 0);
        chk("hold_pending", int'(pendingCount), 4);
        chk("hold_busy", int'(busy), 1);
        nxt();
        wr(1'b0, 8'hEE);
        @(negedge clk);
        chk("ovf_flag", int'(overflow), 1);
        chk("ovf_pending", int'(pendingCount), 4);
        nxt();
        displayActive = 1'b0;
        #1;
        chk("drain_first_we", int'(ramWriteEnabled), 1);
        chk("drain_first_addr", int'(ramAddress), 16'h2000);
        repeat (4) nxt();
        chk("drain_done", int'(pendingCount), 0);
        chk("drain_busy", int'(busy), 0);
        chk("ovf_sticky", int'(overflow), 1);
        wr(1'b0, 8'hB0);
        @(negedge clk);
        chk("ovf_ptr_kept", int'(ramAddress), 16'h2004);
        repeat (2) nxt();

        // Data byte in SECOND discards the low byte and re-arms the toggle
        wr(1'b1, 8'h00); wr(1'b1, 8'h01);
        wr(1'b1, 8'h55); wr(1'b0, 8'h77);
        @(negedge clk);
        chk("toggle_addr", int'(ramAddress), 16'h0100);
        chk("toggle_data", int'(ramData), 8'h77);
        nxt();
        wr(1'b1, 8'h00); wr(1'b1, 8'h30); wr(1'b0, 8'h88);
        @(negedge clk);
        chk("toggle_low_first", int'(ramAddress), 16'h3000);
        repeat (2) nxt();

        // displayActive rising mid-drain holds the remaining entries
        displayActive = 1'b1;
        wr(1'b0, 8'hC0); wr(1'b0, 8'hC1); wr(1'b0, 8'hC2);
        displayActive = 1'b0;
        #1;
        chk("mid_we", int'(ramWriteEnabled), 1);
        chk("mid_addr", int'(ramAddress), 16'h3001);
        nxt();
        displayActive = 1'b1;
        #1;
        chk("mid_drop_we", int'(ramWriteEnabled), 0);
        chk("mid_drop_cs", int'(ramChipSelect), 0);
        repeat (2) nxt();
        chk("mid_kept", int'(pendingCount), 2);
        displayActive = 1'b0;
        #1;
        chk("mid_resume_addr", int'(ramAddress), 16'h3002);
        chk("mid_resume_data", int'(ramData), 8'hC1);
        repeat (2) nxt();
        chk("mid_empty", int'(pendingCount), 0);

        // Reset asserted while draining flushes everything
        displayActive = 1'b1;
        wr(1'b0, 8'hD0); wr(1'b0, 8'hD1); wr(1'b0, 8'hD2);
        chk("rd_pending", int'(pendingCount), 3);
        displayActive = 1'b0;
        #1;
        chk("rd_draining", int'(ramWriteEnabled), 1);
        nxt();
        reset = 1'b1;
        nxt();
        reset = 1'b0;
        chk("rd_pending0", int'(pendingCount), 0);
        chk("rd_we0", int'(ramWriteEnabled), 0);
        chk("rd_ovf0", int'(overflow), 0);
        repeat (3) nxt();
        wr(1'b0, 8'hE0);
        @(negedge clk);
        chk("rd_ptr0_addr", int'(ramAddress), 16'h0000);
        chk("rd_ptr0_data", int'(ramData), 8'hE0);
        repeat (2) nxt();
        chk("sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vram_writer.md
# vram_writer

CPU-side write port into the 64 KB video RAM, the write-direction counterpart to the display's VRAM read path. It accepts byte writes from the CPU bus: control bytes set a 16-bit address pointer, and data bytes are queued with that pointer, which then auto-increments. Queued bytes are committed to VRAM only while the display is not reading (`displayActive` low), so CPU writes never collide with pixel fetches. Sits between the CPU bus decode and the VRAM chip-select/write mux inside the VDP.

## Interface
- `FIFO_LOG2`, default 2: log2 of write-queue depth (default 4 entries).
- `ADDR_WIDTH`, default 16: VRAM address width.

Ports:
- `clk`  in  1  system clock. One clock domain; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `cpuWrite`  in  1  single-cycle write strobe from CPU decode.
- `cpuMode`  in  1  0 = data byte, 1 = control (address) byte. Sampled with `cpuWrite`.
- `cpuData`  in  8  byte being written. Sampled with `cpuWrite`.
- `displayActive`  in  1  high while the display owns VRAM. Comes from sync generator `isActive`.
- `busy`  out  1  queue full; data writes are dropped while high.
- `overflow`  out  1  sticky; set when a data write is dropped.
- `pendingCount`  out  FIFO_LOG2+1  number of queued entries.
- `ramChipSelect`  out  1  VRAM select for the write cycle.
- `ramWriteEnabled`  out  1  VRAM write enable.
- `ramAddress`  out  ADDR_WIDTH  write address. Valid only while `ramWriteEnabled` is high.
- `ramData`  out  8  write data. Valid only while `ramWriteEnabled` is high.

## Operation
- Reset: pointer = 0x0000, address toggle = FIRST, queue empty, `pendingCount` = 0, `overflow` = 0, `busy` = 0, `ramChipSelect` = `ramWriteEnabled` = 0.
- The address toggle is a 2-state FSM with states FIRST and SECOND.
  - Control write in FIRST: latch `cpuData` as the low byte, go to SECOND. Pointer unchanged.
  - Control write in SECOND: pointer = {`cpuData`, latched low}, go to FIRST.
  - Data write in SECOND: discard the latched low byte, go to FIRST. The data byte is handled normally at the old pointer.
- Control writes never use the queue and are accepted even while `busy`.
- Data write when not full:
  - Push {pointer, `cpuData`} onto the queue.
  - Pointer = pointer + 1 mod 2^ADDR_WIDTH (0xFFFF wraps to 0x0000).
- Data write when full (`pendingCount` == depth, evaluated on registered state before any same-cycle pop):
  - The byte is dropped and `overflow` is set.
  - The pointer is NOT incremented.
- `overflow` stays set until reset.
- Changing the pointer does not alter entries already queued.
- Drain rule, combinational from registered state:
  - `ramWriteEnabled` = `ramChipSelect` = !`displayActive` && !empty.
  - `ramAddress`/`ramData` = head entry.
  - The head is popped on each edge where `ramWriteEnabled` is high.
- A push and a pop in the same cycle are both performed; `pendingCount` is unchanged.
- `busy` = (`pendingCount` == depth).

## Timing
- Latency: a data write strobed in cycle N with the queue empty and `displayActive` low appears on the RAM outputs in cycle N+1, and the entry is popped at the end of N+1.
- Throughput: one VRAM write per cycle during blanking.
- Entries drain in FIFO order, one per cycle.
- When `displayActive` goes high, the write enable drops in the same cycle (combinational). No partial or extra write occurs, and the head is retained.
- Reset asserted mid-drain: the queue is flushed and the outputs deassert in the cycle after the reset edge. Queued data is lost.

## Test plan
- Address set and single write:
  - Stimulus: ctrl 0x34, ctrl 0x12, then data 0xAB with `displayActive` = 0.
  - Required: exactly one cycle of `ramWriteEnabled` with addr 0x1234, data 0xAB, one cycle after the strobe.
- Auto-increment and wrap:
  - Stimulus: pointer 0xFFFF, data 0x01 then 0x02.
  - Required: writes go to 0xFFFF and then 0x0000.
- Blanking hold:
  - Stimulus: `displayActive` = 1, four data writes.
  - Required: no write enable; `pendingCount` = 4 and `busy` = 1.
  - Then lower `displayActive`: four consecutive write cycles in order, then `pendingCount` = 0.
- Overflow:
  - Stimulus: queue full, write a fifth data byte.
  - Required: byte dropped, `overflow` = 1, and the pointer is unchanged (the next accepted byte goes to the address the dropped byte would have used).
- Toggle reset and mid-stream:
  - Stimulus: ctrl 0x55, then data 0x77 with pointer 0x0100.
  - Required: 0x77 is written to 0x0100, and the next ctrl byte is treated as a low byte.
  - Stimulus: raise `displayActive` mid-drain.
  - Required: write enable drops the same cycle and the remaining entries are preserved.
- Reset mid-drain:
  - Stimulus: queue holds 3 entries, drain in progress; assert `reset`.
  - Required: `pendingCount` = 0, pointer = 0, `overflow` = 0, and no further writes occur.
